// File: rtl/lut_rr_arbiter.sv
// Round-robin arbiter sharing one registered-output 8x8 LUT among NUM_REQ requesters.
// Optional per-requester grant counters are compiled in with LUT_ARB_STATS_EN.
module lut_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LUT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_addr,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           lut_a,
    input  logic [7:0]           lut_qspo,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data
`ifdef LUT_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]              last_gnt;
    logic [IW-1:0]              gnt_idx;
    logic [NUM_REQ-1:0]         gnt;
    logic                       gnt_any;
    logic [7:0]                 gnt_addr;
    int                         idx;
    int                         gsel;

    // Tag travels alongside the LUT: stage LUT_LAT lines up with lut_qspo.
    logic [LUT_LAT:0]               vld_pipe;
    logic [LUT_LAT:0][NUM_REQ-1:0]  id_pipe;

    // Scan from last_gnt+1 so the most recent winner is checked last.
    always_comb begin
        gnt     = '0;
        gnt_idx = last_gnt;
        gnt_any = 1'b0;
        gsel    = 0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_gnt) + k) % NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
                gsel     = idx;
                gnt_any  = 1'b1;
            end
        end
        gnt_addr = req_addr[gsel*8 +: 8];
    end

    assign req_ready = rst_n ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= IW'(NUM_REQ - 1);
            lut_a     <= '0;
            vld_pipe  <= '0;
            id_pipe   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            if (gnt_any) begin
                last_gnt <= gnt_idx;
                lut_a    <= gnt_addr;
            end
            vld_pipe[0] <= gnt_any;
            id_pipe[0]  <= gnt;
            for (int s = 1; s <= LUT_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
            rsp_valid <= vld_pipe[LUT_LAT] ? id_pipe[LUT_LAT] : '0;
            if (vld_pipe[LUT_LAT])
                rsp_data <= lut_qspo;
        end
    end

`ifdef LUT_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (stats_clr)
                cnt <= '0;
            else if (gnt[i] && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign grant_cnt[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_lut_rr_arbiter.sv
// Directed bench for lut_rr_arbiter with a behavioural LUT and a response delay-line model.
module tb_lut_rr_arbiter;
    localparam int N   = 4;
    localparam int LAT = 1;
    localparam int D   = 2 + LAT;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_addr = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     lut_a;
    logic [7:0]     lut_qspo;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
`ifdef LUT_ARB_STATS_EN
    logic           stats_clr = 1'b0;
    logic [N*16-1:0] grant_cnt;
`endif

    lut_rr_arbiter #(.NUM_REQ(N), .LUT_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .lut_a     (lut_a),
        .lut_qspo  (lut_qspo),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
`ifdef LUT_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lutf(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h5A;
    endfunction

    // Behavioural LUT with LAT registered stages.
    logic [7:0] lq [LAT];
    always_ff @(posedge clk) begin
        lq[0] <= lutf(lut_a);
        for (int i = 1; i < LAT; i++) lq[i] <= lq[i-1];
    end
    assign lut_qspo = lq[LAT-1];

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] addr [N];
    logic [N-1:0] pv [D];
    logic [7:0]   pd [D];
    logic [7:0]   la_exp;
    logic [7:0]   rd_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < D; i++) begin
            pv[i] = '0;
            pd[i] = '0;
        end
        la_exp = '0;
        rd_exp = '0;
    endtask

    // One clock cycle: drive requests, check grant and registered outputs, advance model.
    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] er);
        logic [7:0] ga;
        @(negedge clk);
        req_valid = v;
        for (int i = 0; i < N; i++) req_addr[i*8 +: 8] = addr[i];
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("lut_a", 32'(lut_a), 32'(la_exp));
        chk("rsp_valid", 32'(rsp_valid), 32'(pv[0]));
        if (pv[0] != '0) rd_exp = pd[0];
        chk("rsp_data", 32'(rsp_data), 32'(rd_exp));
        ga = la_exp;
        for (int i = 0; i < N; i++) if (er[i]) ga = addr[i];
        for (int i = 0; i < D-1; i++) begin
            pv[i] = pv[i+1];
            pd[i] = pd[i+1];
        end
        pv[D-1] = er;
        pd[D-1] = lutf(ga);
        la_exp  = ga;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_lut_a", 32'(lut_a), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        clr_model();
    endtask

    initial begin
        for (int i = 0; i < N; i++) addr[i] = '0;
        clr_model();
        rst_pulse();

        // Single lookup, latency 3.
        addr[0] = 8'h3C;
        cyc(4'b0001, 4'b0001);
        repeat (4) cyc(4'b0000, 4'b0000);

        // Lone requester held high wins every cycle.
        addr[2] = 8'h77;
        repeat (3) cyc(4'b0100, 4'b0100);
        repeat (3) cyc(4'b0000, 4'b0000);

        // All four pending: strict rotation with wrap.
        rst_pulse();
        addr[0] = 8'h00; addr[1] = 8'h11; addr[2] = 8'h22; addr[3] = 8'h33;
        for (int r = 0; r < 2; r++) begin
            cyc(4'b1111, 4'b0001);
            cyc(4'b1111, 4'b0010);
            cyc(4'b1111, 4'b0100);
            cyc(4'b1111, 4'b1000);
        end
        repeat (3) cyc(4'b0000, 4'b0000);

        // Requesters 1 and 3 from last_gnt=3.
        rst_pulse();
        cyc(4'b1010, 4'b0010);
        cyc(4'b1010, 4'b1000);
        cyc(4'b1010, 4'b0010);
        cyc(4'b1010, 4'b1000);
        repeat (3) cyc(4'b0000, 4'b0000);

        // Requester 2 withdraws before ever being served.
        cyc(4'b0111, 4'b0001);
        cyc(4'b0011, 4'b0010);
        cyc(4'b0011, 4'b0001);
        cyc(4'b0011, 4'b0010);
        repeat (3) cyc(4'b0000, 4'b0000);

        // Reset with three lookups in flight; requests held during reset.
        cyc(4'b1111, 4'b0100);
        cyc(4'b1111, 4'b1000);
        cyc(4'b1111, 4'b0001);
        rst_pulse();
        repeat (5) cyc(4'b0000, 4'b0000);
        cyc(4'b1111, 4'b0001);
        repeat (3) cyc(4'b0000, 4'b0000);

`ifdef LUT_ARB_STATS_EN
        rst_pulse();
        @(negedge clk);
        req_valid = 4'b0001;
        repeat (70000) @(negedge clk);
        #1;
        chk("cnt0_sat", 32'(grant_cnt[15:0]), 32'h0000FFFF);
        chk("cnt1_zero", 32'(grant_cnt[31:16]), 32'd0);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        req_valid = '0;
        #1;
        chk("cnt0_clr", 32'(grant_cnt[15:0]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
